pic_cmd_scheduler: RTL and testbench



---
 rtl/pic_pkg.sv | 39 +++
 rtl/pic_frame_tx.sv | 114 +++++++++++
 rtl/pic_cmd_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_pic_cmd_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared command codes, state encodings and frame buffer type for the PIC link
package pic_pkg;

    localparam int MAX_FRAME_BYTES = 9;

    localparam logic [7:0] PIC_CMD_VERSION = 8'd1;
    localparam logic [7:0] PIC_CMD_LOGO    = 8'd2;
    localparam logic [7:0] PIC_CMD_IP      = 8'd3;
    localparam logic [7:0] PIC_CMD_BOOT    = 8'd4;
    localparam logic [7:0] PIC_CMD_PTT_ON  = 8'd5;
    localparam logic [7:0] PIC_CMD_PTT_OFF = 8'd6;

    typedef enum logic [1:0] {
        BOOT_WAIT,
        BOOT_VER_WAIT,
        BOOT_HOLD,
        BOOT_RUN
    } boot_state_t;

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_FRAME,
        SCH_GAP
    } sched_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_LOAD,
        TX_DATA,
        TX_LOW,
        TX_HIGH,
        TX_END
    } tx_state_t;

    // Byte 0 is the command code and goes out first.
    typedef logic [MAX_FRAME_BYTES-1:0][7:0] frame_buf_t;

endpackage

// File: rtl/pic_frame_tx.sv
// rtl/pic_frame_tx.sv - serialises one framed, MSB-first transfer onto DATA/CLOCK/EN
module pic_frame_tx
    import pic_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] nbytes,
    input  frame_buf_t buffer,
    output logic       pic_data,
    output logic       pic_clock,
    output logic       pic_en,
    output logic       done
);

    tx_state_t  state;
    tx_state_t  state_next;
    frame_buf_t frame;
    logic [3:0] nbytes_q;
    logic [3:0] byte_idx;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       last_bit;
    logic       last_byte;

    assign last_bit  = (bit_idx == 3'd0);
    assign last_byte = (byte_idx == nbytes_q - 4'd1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= TX_IDLE;
            frame    <= '0;
            nbytes_q <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state <= state_next;
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        frame    <= buffer;
                        nbytes_q <= nbytes;
                    end
                end
                TX_START: byte_idx <= '0;
                TX_LOAD: begin
                    shreg   <= frame[byte_idx];
                    bit_idx <= 3'd7;
                end
                TX_HIGH: begin
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_idx <= bit_idx - 3'd1;
                    if (last_bit) begin
                        byte_idx <= byte_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lines decode straight from the state register, so a reset releases them on the next edge.
    always_comb begin
        state_next = state;
        pic_data   = 1'b1;
        pic_clock  = 1'b1;
        pic_en     = 1'b1;
        done       = 1'b0;
        case (state)
            TX_IDLE: begin
                if (start) begin
                    state_next = TX_START;
                end
            end
            TX_START: begin
                pic_en     = 1'b0;
                state_next = TX_LOAD;
            end
            TX_LOAD: begin
                pic_en     = 1'b0;
                state_next = TX_DATA;
            end
            TX_DATA: begin
                pic_en     = 1'b0;
                pic_data   = shreg[7];
                state_next = TX_LOW;
            end
            TX_LOW: begin
                pic_en     = 1'b0;
                pic_data   = shreg[7];
                pic_clock  = 1'b0;
                state_next = TX_HIGH;
            end
            TX_HIGH: begin
                pic_en   = 1'b0;
                pic_data = shreg[7];
                if (!last_bit) begin
                    state_next = TX_DATA;
                end else if (last_byte) begin
                    state_next = TX_END;
                end else begin
                    state_next = TX_LOAD;
                end
            end
            TX_END: begin
                done       = 1'b1;
                state_next = TX_IDLE;
            end
            default: state_next = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/pic_cmd_scheduler.sv
// rtl/pic_cmd_scheduler.sv - arbitrates front-panel PIC commands and paces frames on the slow clock
module pic_cmd_scheduler
    import pic_pkg::*;
#(
    parameter logic [63:0] FW_VERSION = 64'h0000_6e6f_2076_6572,
    parameter int unsigned BOOT_DELAY = 4000,
    parameter int unsigned LOGO_DELAY = 240000,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ptt,
    input  logic [31:0] ip_addr,
    input  logic        ip_valid,
    input  logic        boot_req,
    output logic        pic_data,
    output logic        pic_clock,
    output logic        pic_en,
    output logic        busy,
    output logic        cmd_done,
    output logic [7:0]  last_cmd
);

    logic         ptt_meta;
    logic         ptt_sync;
    logic         ptt_sent;
    logic         ptt_req;
    logic         ver_pend;
    logic         logo_pend;
    logic         ip_pend;
    logic         boot_pend;
    logic [31:0]  ip_shadow;
    logic [31:0]  boot_cnt;
    logic [31:0]  gap_cnt;
    boot_state_t  boot_state;
    boot_state_t  boot_next;
    sched_state_t sched_state;
    sched_state_t sched_next;
    logic         ver_set;
    logic         logo_set;
    logic         grant_ptt;
    logic         grant_boot;
    logic         grant_ip;
    logic         grant_ver;
    logic         grant_logo;
    logic         tx_start;
    logic         tx_done;
    logic [3:0]   tx_nbytes;
    frame_buf_t   tx_buf;
    logic [7:0]   grant_cmd;
    logic [7:0]   cur_cmd;
    logic [7:0]   last_cmd_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptt_meta <= 1'b0;
            ptt_sync <= 1'b0;
        end else begin
            ptt_meta <= ptt;
            ptt_sync <= ptt_meta;
        end
    end

    // PTT is held off until the panel has shown the firmware version.
    assign ptt_req = (ptt_sync != ptt_sent) &&
                     ((boot_state == BOOT_HOLD) || (boot_state == BOOT_RUN));

    always_comb begin
        boot_next = boot_state;
        ver_set   = 1'b0;
        logo_set  = 1'b0;
        case (boot_state)
            BOOT_WAIT: begin
                if (boot_cnt == BOOT_DELAY - 1) begin
                    ver_set   = 1'b1;
                    boot_next = BOOT_VER_WAIT;
                end
            end
            BOOT_VER_WAIT: begin
                if (tx_done && (cur_cmd == PIC_CMD_VERSION)) begin
                    boot_next = BOOT_HOLD;
                end
            end
            BOOT_HOLD: begin
                if (boot_cnt == LOGO_DELAY - 1) begin
                    logo_set  = 1'b1;
                    boot_next = BOOT_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            boot_state <= BOOT_WAIT;
            boot_cnt   <= '0;
        end else begin
            boot_state <= boot_next;
            if (boot_next != boot_state) begin
                boot_cnt <= '0;
            end else if ((boot_state == BOOT_WAIT) || (boot_state == BOOT_HOLD)) begin
                boot_cnt <= boot_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        sched_next = sched_state;
        grant_ptt  = 1'b0;
        grant_boot = 1'b0;
        grant_ip   = 1'b0;
        grant_ver  = 1'b0;
        grant_logo = 1'b0;
        grant_cmd  = 8'd0;
        tx_nbytes  = 4'd0;
        tx_buf     = '0;
        case (sched_state)
            SCH_IDLE: begin
                if (ptt_req) begin
                    grant_ptt = 1'b1;
                    grant_cmd = ptt_sync ? PIC_CMD_PTT_ON : PIC_CMD_PTT_OFF;
                    tx_nbytes = 4'd1;
                end else if (boot_pend) begin
                    grant_boot = 1'b1;
                    grant_cmd  = PIC_CMD_BOOT;
                    tx_nbytes  = 4'd1;
                end else if (ip_pend) begin
                    grant_ip  = 1'b1;
                    grant_cmd = PIC_CMD_IP;
                    tx_nbytes = 4'd5;
                    tx_buf[1] = ip_shadow[31:24];
                    tx_buf[2] = ip_shadow[23:16];
                    tx_buf[3] = ip_shadow[15:8];
                    tx_buf[4] = ip_shadow[7:0];
                end else if (ver_pend) begin
                    grant_ver = 1'b1;
                    grant_cmd = PIC_CMD_VERSION;
                    tx_nbytes = 4'd9;
                    for (int i = 0; i < 8; i++) begin
                        tx_buf[i+1] = FW_VERSION[63-8*i -: 8];
                    end
                end else if (logo_pend) begin
                    grant_logo = 1'b1;
                    grant_cmd  = PIC_CMD_LOGO;
                    tx_nbytes  = 4'd1;
                end
                tx_buf[0] = grant_cmd;
                if (grant_ptt || grant_boot || grant_ip || grant_ver || grant_logo) begin
                    sched_next = SCH_FRAME;
                end
            end
            SCH_FRAME: begin
                if (tx_done) begin
                    sched_next = SCH_GAP;
                end
            end
            SCH_GAP: begin
                if (gap_cnt == GAP_CYCLES - 1) begin
                    sched_next = SCH_IDLE;
                end
            end
            default: sched_next = SCH_IDLE;
        endcase
    end

    assign tx_start = grant_ptt | grant_boot | grant_ip | grant_ver | grant_logo;

    // Set terms follow the clear terms so a request landing on its grant cycle is kept.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sched_state <= SCH_IDLE;
            gap_cnt     <= '0;
            cur_cmd     <= '0;
            last_cmd_q  <= '0;
            ptt_sent    <= 1'b0;
            ver_pend    <= 1'b0;
            logo_pend   <= 1'b0;
            boot_pend   <= 1'b0;
            ip_pend     <= 1'b0;
            ip_shadow   <= '0;
        end else begin
            sched_state <= sched_next;
            gap_cnt     <= (sched_state == SCH_GAP) ? gap_cnt + 32'd1 : 32'd0;
            if (tx_start) begin
                cur_cmd <= grant_cmd;
            end
            if (tx_done) begin
                last_cmd_q <= cur_cmd;
            end
            if (grant_ptt) begin
                ptt_sent <= ptt_sync;
            end
            if (grant_ver)  ver_pend  <= 1'b0;
            if (ver_set)    ver_pend  <= 1'b1;
            if (grant_logo) logo_pend <= 1'b0;
            if (logo_set)   logo_pend <= 1'b1;
            if (grant_boot) boot_pend <= 1'b0;
            if (boot_req)   boot_pend <= 1'b1;
            if (grant_ip)   ip_pend   <= 1'b0;
            if (ip_valid) begin
                ip_pend   <= 1'b1;
                ip_shadow <= ip_addr;
            end
        end
    end

    pic_frame_tx u_frame_tx (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (tx_start),
        .nbytes    (tx_nbytes),
        .buffer    (tx_buf),
        .pic_data  (pic_data),
        .pic_clock (pic_clock),
        .pic_en    (pic_en),
        .done      (tx_done)
    );

    assign busy     = (sched_state != SCH_IDLE);
    assign cmd_done = tx_done;
    assign last_cmd = tx_done ? cur_cmd : last_cmd_q;

endmodule

// File: tb/tb_pic_cmd_scheduler.sv
// tb/tb_pic_cmd_scheduler.sv - directed self-checking bench for pic_cmd_scheduler
module tb_pic_cmd_scheduler;

    localparam int GAP = 16;

    logic        clock;
    logic        reset_n;
    logic        ptt;
    logic [31:0] ip_addr;
    logic        ip_valid;
    logic        boot_req;
    logic        pic_data;
    logic        pic_clock;
    logic        pic_en;
    logic        busy;
    logic        cmd_done;
    logic [7:0]  last_cmd;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];
    logic        prev_clk = 1'b1;
    logic [7:0]  sh = 8'h00;
    int          bitn = 0;
    logic        idle_ok;
    logic        flag;
    int          w;
    int          len;

    pic_cmd_scheduler #(
        .FW_VERSION (64'h0123_4567_89AB_CDEF),
        .BOOT_DELAY (10),
        .LOGO_DELAY (50),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ptt       (ptt),
        .ip_addr   (ip_addr),
        .ip_valid  (ip_valid),
        .boot_req  (boot_req),
        .pic_data  (pic_data),
        .pic_clock (pic_clock),
        .pic_en    (pic_en),
        .busy      (busy),
        .cmd_done  (cmd_done),
        .last_cmd  (last_cmd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Byte capture on the CLOCK rising edge, as the PIC sees it.
    always @(negedge clock) begin
        if (pic_en !== 1'b0) begin
            bitn = 0;
        end else if (prev_clk === 1'b0 && pic_clock === 1'b1) begin
            sh = {sh[6:0], pic_data};
            bitn++;
            if (bitn == 8) begin
                rx_q.push_back(sh);
                bitn = 0;
            end
        end
        prev_clk = pic_clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [8:0] rxb(input int i);
        if (i < rx_q.size()) return {1'b0, rx_q[i]};
        return 9'h1FF;
    endfunction

    task automatic chk_frame(input string tag);
        chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), rxb(i), {1'b0, exp_q[i]});
        end
    endtask

    task automatic wait_start(input string tag, output int wc);
        wc = 0;
        idle_ok = 1'b1;
        while (pic_en === 1'b1 && wc < 2000) begin
            if (pic_clock !== 1'b1 || pic_data !== 1'b1) idle_ok = 1'b0;
            tick(1);
            wc++;
        end
        chk({tag, "_started"}, pic_en, 1'b0);
        rx_q.delete();
    endtask

    task automatic wait_done(input int t0, output int l);
        l = t0;
        while (cmd_done !== 1'b1 && l < 400) begin
            tick(1);
            l++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        ptt      = 1'b0;
        ip_addr  = 32'h0;
        ip_valid = 1'b0;
        boot_req = 1'b0;
        tick(3);
        chk("rst_data",  pic_data,  1'b1);
        chk("rst_clock", pic_clock, 1'b1);
        chk("rst_en",    pic_en,    1'b1);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_done",  cmd_done,  1'b0);
        chk("rst_last",  last_cmd,  8'h00);

        // Boot: version frame begins on the 11th edge after release.
        reset_n = 1'b1;
        tick(10);
        chk("boot_en_e10", pic_en, 1'b1);
        tick(1);
        chk("boot_en_e11", pic_en, 1'b0);
        chk("boot_busy", busy, 1'b1);
        wait_start("ver", w);
        wait_done(1, len);
        chk("ver_len", len, 227);
        chk("ver_last", last_cmd, 8'h01);
        exp_q = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        chk_frame("ver");

        // Logo: HOLD spans 50 cycles after done, then one arbitration cycle.
        wait_start("logo", w);
        chk("logo_delay", w, 52);
        chk("logo_idle", idle_ok, 1'b1);
        wait_done(1, len);
        chk("logo_len", len, 27);
        chk("logo_last", last_cmd, 8'h02);
        exp_q = '{8'h02};
        chk_frame("logo");

        // Two IP pulses before the grant: only the latest address goes out.
        ip_valid = 1'b1;
        ip_addr  = 32'hC0A8_0164;
        tick(1);
        chk("done_single", cmd_done, 1'b0);
        ip_addr = 32'hC0A8_0165;
        tick(1);
        ip_valid = 1'b0;
        wait_start("ip", w);
        chk("ip_gap", w, 16);
        ptt = 1'b1;
        tick(4);
        ptt = 1'b0;
        wait_done(5, len);
        chk("ip_len", len, 127);
        chk("ip_last", last_cmd, 8'h03);
        exp_q = '{8'h03, 8'hC0, 8'hA8, 8'h01, 8'h65};
        chk_frame("ip");

        // Neither a second IP frame nor a PTT frame from the toggle-and-return.
        flag = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (pic_en !== 1'b1) flag = 1'b1;
        end
        chk("no_extra_frame", flag, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // PTT, boot and IP all pending behind a boot frame.
        boot_req = 1'b1;
        tick(1);
        boot_req = 1'b0;
        wait_start("boot1", w);
        chk("boot1_lat", w, 1);
        ptt      = 1'b1;
        boot_req = 1'b1;
        ip_valid = 1'b1;
        ip_addr  = 32'h0A00_0002;
        tick(1);
        boot_req = 1'b0;
        ip_valid = 1'b0;
        wait_done(2, len);
        chk("boot1_len", len, 27);
        exp_q = '{8'h04};
        chk_frame("boot1");

        wait_start("pttq", w);
        chk("pttq_gap", w >= GAP, 1'b1);
        chk("pttq_idle", idle_ok, 1'b1);
        wait_done(1, len);
        chk("pttq_last", last_cmd, 8'h05);
        exp_q = '{8'h05};
        chk_frame("pttq");

        wait_start("bootq", w);
        chk("bootq_gap", w >= GAP, 1'b1);
        chk("bootq_idle", idle_ok, 1'b1);
        wait_done(1, len);
        chk("bootq_last", last_cmd, 8'h04);
        exp_q = '{8'h04};
        chk_frame("bootq");

        wait_start("ipq", w);
        chk("ipq_gap", w >= GAP, 1'b1);
        chk("ipq_idle", idle_ok, 1'b1);
        wait_done(1, len);
        chk("ipq_len", len, 127);
        chk("ipq_last", last_cmd, 8'h03);
        exp_q = '{8'h03, 8'h0A, 8'h00, 8'h00, 8'h02};
        chk_frame("ipq");

        // Second boot: PTT rising mid-version is sent before the logo.
        ptt     = 1'b0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(11);
        chk("rb_en_e11", pic_en, 1'b0);
        wait_start("rb_ver", w);
        tick(20);
        ptt = 1'b1;
        wait_done(21, len);
        chk("rb_ver_len", len, 227);
        chk("rb_ver_last", last_cmd, 8'h01);
        wait_start("rb_ptt", w);
        wait_done(1, len);
        chk("rb_ptt_last", last_cmd, 8'h05);
        exp_q = '{8'h05};
        chk_frame("rb_ptt");
        wait_start("rb_logo", w);
        wait_done(1, len);
        chk("rb_logo_last", last_cmd, 8'h02);

        // Reset in the middle of an IP frame.
        ip_valid = 1'b1;
        ip_addr  = 32'hC0A8_0164;
        tick(1);
        ip_valid = 1'b0;
        wait_start("rb_ip", w);
        tick(10);
        chk("mid_data_low", pic_data, 1'b0);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_en",    pic_en,    1'b1);
        chk("mid_rst_clock", pic_clock, 1'b1);
        chk("mid_rst_data",  pic_data,  1'b1);
        chk("mid_rst_busy",  busy,      1'b0);
        chk("mid_rst_done",  cmd_done,  1'b0);
        chk("mid_rst_last",  last_cmd,  8'h00);
        tick(2);
        reset_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (pic_en !== 1'b1 || cmd_done !== 1'b0) flag = 1'b1;
        end
        chk("rr_quiet", flag, 1'b0);
        tick(1);
        chk("rr_en_e11", pic_en, 1'b0);
        wait_start("rr_ver", w);
        wait_done(1, len);
        chk("rr_ver_len", len, 227);
        exp_q = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        chk_frame("rr_ver");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
